fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Synchronous FIFO controller; sits directly upstream of the FIFO's dual-port RAM (64x32 default) and drives its write enable, write address, write data and read address.
- Owns read/write pointers, occupancy count, full/empty and threshold flags, and sticky error flags.
- Returns the RAM's combinational read data as the FIFO head word (first-word-fall-through).
- The FIFO top level instantiates this block plus the RAM.

Parameters:
ADDRESS_WIDTH, 6, RAM address bits; DEPTH = 2**ADDRESS_WIDTH entries
DATA_WIDTH, 32, data word width
AF_MARGIN, 4, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 4, almost_empty asserts when count <= AE_MARGIN

Ports:
fifoctrl_clk_i  in  1  clock, rising edge
fifoctrl_rst_i  in  1  synchronous active-high reset
fifoctrl_clear_i  in  1  synchronous flush; same effect as reset on all state
fifoctrl_push_i  in  1  write request
fifoctrl_wdata_i  in  DATA_WIDTH  write data
fifoctrl_pop_i  in  1  read request; consumes current head word
fifoctrl_rdata_o  out  DATA_WIDTH  head word; valid while empty_o=0
fifoctrl_full_o  out  1  no free entry
fifoctrl_empty_o  out  1  no stored entry
fifoctrl_afull_o  out  1  almost full
fifoctrl_aempty_o  out  1  almost empty
fifoctrl_count_o  out  ADDRESS_WIDTH+1  occupancy 0..DEPTH
fifoctrl_overflow_o  out  1  sticky: push attempted while full
fifoctrl_underflow_o  out  1  sticky: pop attempted while empty
ram_we_o  out  1  RAM write enable
ram_waddr_o  out  ADDRESS_WIDTH  RAM write address
ram_raddr_o  out  ADDRESS_WIDTH  RAM read address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, combinational from ram_raddr_o

Behaviour:
- Clock/reset: one clock fifoctrl_clk_i; reset fifoctrl_rst_i is synchronous and active-high.
- Pointers: wr_ptr and rd_ptr are ADDRESS_WIDTH+1 bits. The low bits address the RAM; the MSB is the wrap bit.
- Flag decode:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDRESS_WIDTH+1).
- Accept logic:
  - push_acc = push_i & ~full.
  - pop_acc = pop_i & ~empty.
  - Both are evaluated on registered state. No bypass: a push into an empty FIFO is not poppable in the same cycle.
- RAM drive (combinational):
  - ram_we_o = push_acc & ~rst_i & ~clear_i.
  - ram_waddr_o = wr_ptr low bits; ram_wdata_o = wdata_i.
  - ram_raddr_o = rd_ptr low bits; rdata_o = ram_rdata_i.
- Pointer and count update, at the clock edge:
  - push_acc increments wr_ptr; pop_acc increments rd_ptr.
  - Both increment wrap naturally through the MSB.
  - Count is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency:
  - Data pushed at edge N appears on rdata_o after edge N if the FIFO was empty; empty_o deasserts after edge N.
  - A pop at edge N exposes the next word after edge N.
- Thresholds: full/empty/afull/aempty are decoded from registered pointers/count, so they are glitch-free relative to the clock and never combinational from push_i/pop_i.
- Boundary cases:
  - Full with push and pop: pop accepted, push rejected, overflow set; count becomes DEPTH-1.
  - Empty with push and pop: push accepted, pop rejected, underflow set; count becomes 1.
  - Neither full nor empty with push and pop: both accepted; count unchanged.
  - Pointer wrap from DEPTH-1 to 0 in the low bits toggles the MSB; full/empty remain correct across any number of wraps.
- Sticky flags: overflow/underflow set on the edge following the offending request. They clear only on rst_i or clear_i.
- Reset/clear mid-operation: any push/pop in the same cycle is discarded and no RAM write occurs. RAM contents are not cleared.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, aempty = 1.
  - full = 0, afull = 0 (AF_MARGIN < DEPTH required).
  - overflow = 0, underflow = 0.
  - ram_we_o = 0.
  - rdata_o is don't-care while empty.
- Parameter checks:
  - AF_MARGIN and AE_MARGIN must be < DEPTH.
  - ADDRESS_WIDTH >= 1.
  - An out-of-range value stops elaboration with a $error.

Decomposition:
- Shared package fifo_pkg holds:
  - Default ADDRESS_WIDTH/DATA_WIDTH constants.
  - DEPTH derivation function.
  - Pointer-width constant.
- Sub-module: fifo_ptr (one counter with wrap bit, increment enable, clear), instantiated twice for wr_ptr and rd_ptr.
- Flag, count and sticky logic stay in fifo_ctrl.
- The RAM is instantiated beside fifo_ctrl at FIFO top level, not inside it.

Test Plan:
1. Reset, then push 0xA0..0xA3 on four consecutive cycles -> count=4; rdata_o=0xA0 one cycle after the first push; empty_o=0 from that edge.
2. Fill to 64 -> full_o=1 and afull_o=1 (from count 60); a further push of 0xDEAD -> ram_we_o=0, overflow_o=1, count stays 64.
3. Pop all 64 entries -> data returns in push order; empty_o=1 after the last pop; a further pop -> underflow_o=1, count=0.
4. Hold count=10 and assert push+pop for 200 cycles (pointers wrap three times) -> count stays 10, data order preserved, full/empty never assert.
5. Full FIFO with push+pop in the same cycle -> count=63, overflow_o=1. Empty FIFO with push+pop -> count=1, underflow_o=1, rdata_o = pushed word.
6. Count=20, assert clear_i together with push -> next cycle count=0, empty_o=1, sticky flags 0, ram_we_o=0 during the clear cycle. Repeat using rst_i: same result.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller slice.
package fifo_pkg;

  localparam int unsigned DefAddrWidth = 6;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefPtrWidth  = DefAddrWidth + 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: binary counter whose MSB is the wrap bit; clear has priority over increment.
module fifo_ptr #(
  parameter int unsigned Width = fifo_pkg::DefPtrWidth
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM; first-word-fall-through head.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned AF_MARGIN     = 4,
  parameter int unsigned AE_MARGIN     = 4
) (
  input  logic                   fifoctrl_clk_i,
  input  logic                   fifoctrl_rst_i,
  input  logic                   fifoctrl_clear_i,
  input  logic                   fifoctrl_push_i,
  input  logic [DATA_WIDTH-1:0]  fifoctrl_wdata_i,
  input  logic                   fifoctrl_pop_i,
  output logic [DATA_WIDTH-1:0]  fifoctrl_rdata_o,
  output logic                   fifoctrl_full_o,
  output logic                   fifoctrl_empty_o,
  output logic                   fifoctrl_afull_o,
  output logic                   fifoctrl_aempty_o,
  output logic [ADDRESS_WIDTH:0] fifoctrl_count_o,
  output logic                   fifoctrl_overflow_o,
  output logic                   fifoctrl_underflow_o,
  output logic                   ram_we_o,
  output logic [ADDRESS_WIDTH-1:0] ram_waddr_o,
  output logic [ADDRESS_WIDTH-1:0] ram_raddr_o,
  output logic [DATA_WIDTH-1:0]  ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]  ram_rdata_i
);

  localparam int unsigned Depth = fifo_depth(ADDRESS_WIDTH);
  localparam int unsigned PtrW  = ADDRESS_WIDTH + 1;

  if (ADDRESS_WIDTH < 1) begin : gen_bad_aw
    $error("fifo_ctrl: ADDRESS_WIDTH must be >= 1");
  end
  if (AF_MARGIN >= Depth) begin : gen_bad_af
    $error("fifo_ctrl: AF_MARGIN must be < DEPTH");
  end
  if (AE_MARGIN >= Depth) begin : gen_bad_ae
    $error("fifo_ctrl: AE_MARGIN must be < DEPTH");
  end

  localparam logic [PtrW-1:0] AfLevel = PtrW'(Depth - AF_MARGIN);
  localparam logic [PtrW-1:0] AeLevel = PtrW'(AE_MARGIN);

  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            flush;
  logic            full, empty;
  logic            push_acc, pop_acc;

  assign flush = fifoctrl_rst_i | fifoctrl_clear_i;

  // Flags come only from registered pointers, never from push/pop inputs.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]) &&
                 (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]);

  assign push_acc = fifoctrl_push_i & ~full;
  assign pop_acc  = fifoctrl_pop_i & ~empty;

  fifo_ptr #(
    .Width (PtrW)
  ) u_wr_ptr (
    .clk_i (fifoctrl_clk_i),
    .clr_i (flush),
    .inc_i (push_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(
    .Width (PtrW)
  ) u_rd_ptr (
    .clk_i (fifoctrl_clk_i),
    .clr_i (flush),
    .inc_i (pop_acc),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q | (fifoctrl_push_i & full);
    underflow_d = underflow_q | (fifoctrl_pop_i & empty);
    if (flush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push_acc && !pop_acc) begin
      count_d = count_q + PtrW'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - PtrW'(1);
    end
  end

  always_ff @(posedge fifoctrl_clk_i) begin
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  assign ram_we_o    = push_acc & ~flush;
  assign ram_waddr_o = wr_ptr[ADDRESS_WIDTH-1:0];
  assign ram_wdata_o = fifoctrl_wdata_i;
  assign ram_raddr_o = rd_ptr[ADDRESS_WIDTH-1:0];

  assign fifoctrl_rdata_o     = ram_rdata_i;
  assign fifoctrl_full_o      = full;
  assign fifoctrl_empty_o     = empty;
  assign fifoctrl_afull_o     = (count_q >= AfLevel);
  assign fifoctrl_aempty_o    = (count_q <= AeLevel);
  assign fifoctrl_count_o     = count_q;
  assign fifoctrl_overflow_o  = overflow_q;
  assign fifoctrl_underflow_o = underflow_q;

endmodule
